vend_session_arbiter: RTL and testbench

- Shares one vending core between NUM_PANELS customer front panels. Only one panel owns the core at a time.
- Grants ownership round-robin, starts one purchase session, and watches it for completion, abandonment or inactivity timeout.
- On abandonment or timeout, forces a cancel into the core, which returns the inserted coins.
- Sits between the panel input logic and the core's c1/c2/inN/cnl inputs. The panel-to-core input mux is steered by gnt.

---
 rtl/vend_session_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_vend_session_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_session_arbiter.sv
// Round-robin session arbiter sharing one vending core between NUM_PANELS front panels.
// Define VEND_ARB_STATS_EN to add the sess_cnt/tmo_cnt statistics outputs and release logging.
module vend_session_arbiter #(
    parameter int NUM_PANELS     = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_PANELS-1:0] req,
    input  logic [NUM_PANELS-1:0] act,
    input  logic                  core_done,
    output logic [NUM_PANELS-1:0] gnt,
    output logic [2:0]            owner_id,
    output logic                  core_start,
    output logic                  force_cnl,
    output logic                  busy
`ifdef VEND_ARB_STATS_EN
    ,
    output logic [15:0]           sess_cnt,
    output logic [15:0]           tmo_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        ACTIVE,
        CANCEL,
        RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]       LAST_ID  = 3'(NUM_PANELS - 1);

    state_t                  state;
    logic [2:0]              owner;
    logic [2:0]              ptr;
    logic [CNT_W-1:0]        cnt;
    logic [2:0]              pick_idx;
    logic [NUM_PANELS-1:0]   owner_mask;
    logic                    owner_req;
    logic                    owner_act;
    logic                    tmo_hit;

    // First requester at or after the pointer, wrapping to the lowest requester.
    function automatic logic [2:0] pick(input logic [NUM_PANELS-1:0] r, input logic [2:0] p);
        logic [2:0]            sel_hi;
        logic [2:0]            sel_lo;
        logic                  hit_hi;
        logic [NUM_PANELS-1:0] sh;
        sel_hi = '0;
        sel_lo = '0;
        hit_hi = 1'b0;
        for (int j = NUM_PANELS - 1; j >= 0; j--) begin
            sh = r >> j;
            if (sh[0]) begin
                sel_lo = 3'(j);
                if (3'(j) >= p) begin
                    sel_hi = 3'(j);
                    hit_hi = 1'b1;
                end
            end
        end
        return hit_hi ? sel_hi : sel_lo;
    endfunction

    assign pick_idx   = pick(req, ptr);
    assign owner_mask = NUM_PANELS'(1) << owner;
    assign owner_req  = |(req & owner_mask);
    assign owner_act  = |(act & owner_mask);
    assign tmo_hit    = (cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            gnt        <= '0;
            owner_id   <= '0;
            owner      <= '0;
            core_start <= 1'b0;
            force_cnl  <= 1'b0;
            busy       <= 1'b0;
            ptr        <= '0;
            cnt        <= '0;
        end else begin
            core_start <= 1'b0;
            force_cnl  <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt      <= NUM_PANELS'(1) << pick_idx;
                        owner    <= pick_idx;
                        owner_id <= pick_idx;
                        busy     <= 1'b1;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    core_start <= 1'b1;
                    cnt        <= '0;
                    state      <= ACTIVE;
                end
                ACTIVE: begin
                    // A completion in the same cycle as a timeout/abandon suppresses the cancel.
                    if (core_done) begin
                        gnt      <= '0;
                        owner_id <= '0;
                        state    <= RELEASE;
                    end else if (!owner_req || tmo_hit) begin
                        force_cnl <= 1'b1;
                        state     <= CANCEL;
                    end else if (owner_act) begin
                        cnt <= '0;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CANCEL: begin
                    if (core_done) begin
                        gnt      <= '0;
                        owner_id <= '0;
                        state    <= RELEASE;
                    end
                end
                RELEASE: begin
                    ptr   <= (owner == LAST_ID) ? 3'd0 : owner + 3'd1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    gnt      <= '0;
                    owner_id <= '0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

`ifdef VEND_ARB_STATS_EN
    typedef enum logic [1:0] {
        EXIT_DONE,
        EXIT_ABANDON,
        EXIT_TIMEOUT
    } exit_t;

    exit_t exit_rsn;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sess_cnt <= '0;
            tmo_cnt  <= '0;
            exit_rsn <= EXIT_DONE;
        end else begin
            case (state)
                ACTIVE: begin
                    if (core_done) begin
                        exit_rsn <= EXIT_DONE;
                    end else if (!owner_req) begin
                        exit_rsn <= EXIT_ABANDON;
                        tmo_cnt  <= sat_inc(tmo_cnt);
                    end else if (tmo_hit) begin
                        exit_rsn <= EXIT_TIMEOUT;
                        tmo_cnt  <= sat_inc(tmo_cnt);
                    end
                end
                RELEASE: begin
                    if (exit_rsn == EXIT_DONE)
                        sess_cnt <= sat_inc(sess_cnt);
                    $display("vend_session_arbiter: release owner_id=%0d reason=%s", owner,
                             (exit_rsn == EXIT_DONE) ? "done" :
                             (exit_rsn == EXIT_ABANDON) ? "abandon" : "timeout");
                end
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_vend_session_arbiter.sv
// Randomized and directed bench for vend_session_arbiter against a session-level reference model.
module tb_vend_session_arbiter;

    localparam int NP  = 4;
    localparam int TMO = 8;

    logic          clk;
    logic          rst;
    logic [NP-1:0] req;
    logic [NP-1:0] act;
    logic          core_done;
    logic [NP-1:0] gnt;
    logic [2:0]    owner_id;
    logic          core_start;
    logic          force_cnl;
    logic          busy;
`ifdef VEND_ARB_STATS_EN
    logic [15:0]   sess_cnt;
    logic [15:0]   tmo_cnt;
`endif

    vend_session_arbiter #(
        .NUM_PANELS    (NP),
        .TIMEOUT_CYCLES(TMO),
        .CNT_W         (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .act       (act),
        .core_done (core_done),
        .gnt       (gnt),
        .owner_id  (owner_id),
        .core_start(core_start),
        .force_cnl (force_cnl),
        .busy      (busy)
`ifdef VEND_ARB_STATS_EN
        ,
        .sess_cnt  (sess_cnt),
        .tmo_cnt   (tmo_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Session-level reference: who owns the core, how long since grant, how long quiet.
    int         m_own;
    int         m_ptr;
    int         m_age;
    int         m_quiet;
    bit         m_cancelled;
    bit         m_closing;
    logic [3:0] e_gnt;
    logic [2:0] e_id;
    logic       e_start;
    logic       e_cnl;
    logic       e_busy;

    task automatic model_reset();
        m_own = -1; m_ptr = 0; m_age = 0; m_quiet = 0;
        m_cancelled = 0; m_closing = 0;
        e_gnt = '0; e_id = '0; e_start = 0; e_cnl = 0; e_busy = 0;
    endtask

    function automatic bit bit_of(input logic [3:0] v, input int i);
        logic [3:0] s;
        s = v >> i;
        return s[0];
    endfunction

    task automatic model_step(input logic [3:0] r, input logic [3:0] a, input logic d);
        bit found;
        int idx;
        e_start = 0;
        e_cnl   = 0;
        if (m_closing) begin
            m_closing = 0;
            m_ptr     = (m_own + 1) % NP;
            m_own     = -1;
        end else if (m_own < 0) begin
            found = 0;
            for (int k = 0; k < NP; k++) begin
                idx = (m_ptr + k) % NP;
                if (!found && bit_of(r, idx)) begin
                    found = 1;
                    m_own = idx;
                end
            end
            m_age = 0;
            m_cancelled = 0;
        end else if (m_age == 0) begin
            m_age   = 1;
            m_quiet = 0;
            e_start = 1;
        end else if (d) begin
            m_closing = 1;
        end else if (!m_cancelled) begin
            if (!bit_of(r, m_own) || m_quiet == TMO - 1) begin
                m_cancelled = 1;
                e_cnl = 1;
            end else begin
                m_quiet = bit_of(a, m_own) ? 0 : m_quiet + 1;
            end
        end
        e_busy = (m_own >= 0);
        e_gnt  = (m_own >= 0 && !m_closing) ? 4'(1 << m_own) : 4'd0;
        e_id   = (m_own >= 0 && !m_closing) ? 3'(m_own) : 3'd0;
    endtask

    task automatic compare_all();
        chk("gnt",        32'(gnt),        32'(e_gnt));
        chk("owner_id",   32'(owner_id),   32'(e_id));
        chk("core_start", 32'(core_start), 32'(e_start));
        chk("force_cnl",  32'(force_cnl),  32'(e_cnl));
        chk("busy",       32'(busy),       32'(e_busy));
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] a, input logic d);
        req = r; act = a; core_done = d;
        @(posedge clk);
        model_step(r, a, d);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        req = '0; act = '0; core_done = 0;
        @(negedge clk);
        rst = 0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        rst = 1;
    endtask

    task automatic wait_start(input logic [3:0] r, input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(r, 4'd0, 1'b0);
            if (core_start) seen = 1;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        logic [2:0] rr_order [4];
        logic [3:0] rq;
        logic [3:0] ra;
        bit         seen;
        int         n;
        int         cnl_seen;

        rr_order[0] = 3'd0; rr_order[1] = 3'd1; rr_order[2] = 3'd3; rr_order[3] = 3'd0;
        rst = 1; req = '0; act = '0; core_done = 0;
        model_reset();
        do_reset();

        // Single request: grant after 1 clock, start after 2, release on done.
        step(4'b0010, 4'd0, 1'b0);
        chk("single_gnt", 32'(gnt), 32'h2);
        chk("single_id",  32'(owner_id), 32'd1);
        step(4'b0010, 4'd0, 1'b0);
        chk("single_start", 32'(core_start), 32'd1);
        step(4'b0010, 4'd0, 1'b0);
        step(4'b0010, 4'd0, 1'b1);
        chk("single_rel_gnt", 32'(gnt), 32'd0);
        step(4'b0010, 4'd0, 1'b0);
        chk("single_idle_busy", 32'(busy), 32'd0);

        // Round-robin over 1011 from a fresh pointer.
        do_reset();
        for (int s = 0; s < 4; s++) begin
            seen = 0;
            for (int i = 0; i < 10 && !seen; i++) begin
                step(4'b1011, 4'd0, 1'b0);
                if (gnt != 0) seen = 1;
            end
            chk("rr_gnt_seen", 32'(seen), 32'd1);
            chk("rr_owner", 32'(owner_id), 32'(rr_order[s]));
            chk("rr_onehot", 32'($countones(gnt)), 32'd1);
            wait_start(4'b1011, "rr_start_seen");
            for (int i = 0; i < 4; i++) step(4'b1011, 4'd0, 1'b0);
            step(4'b1011, 4'd0, 1'b1);
        end
        step(4'b0000, 4'd0, 1'b0);
        step(4'b0000, 4'd0, 1'b0);

        // Timeout with owner 2 and no activity.
        wait_start(4'b0100, "tmo_start_seen");
        n = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(4'b0100, 4'd0, 1'b0);
            n++;
            if (force_cnl) seen = 1;
        end
        chk("tmo_latency", 32'(n), 32'd8);
        step(4'b0100, 4'd0, 1'b0);
        chk("tmo_width", 32'(force_cnl), 32'd0);
        for (int i = 0; i < 3; i++) step(4'b0100, 4'd0, 1'b0);
        chk("tmo_hold_gnt", 32'(gnt), 32'h4);
        step(4'b0100, 4'd0, 1'b1);
        chk("tmo_rel_gnt", 32'(gnt), 32'd0);
        step(4'b0000, 4'd0, 1'b0);
        step(4'b0000, 4'd0, 1'b0);

        // Activity every 6 cycles keeps the session alive.
        wait_start(4'b0100, "keep_start_seen");
        cnl_seen = 0;
        for (int i = 0; i < 50; i++) begin
            step(4'b0100, (i % 6 == 5) ? 4'b0100 : 4'b0000, 1'b0);
            if (force_cnl) cnl_seen++;
        end
        chk("keep_no_cnl", 32'(cnl_seen), 32'd0);
        step(4'b0100, 4'd0, 1'b1);
        step(4'b0000, 4'd0, 1'b0);
        step(4'b0000, 4'd0, 1'b0);

        // core_done in the timeout cycle wins over the cancel.
        wait_start(4'b0100, "coll_start_seen");
        for (int i = 0; i < 7; i++) step(4'b0100, 4'd0, 1'b0);
        step(4'b0100, 4'd0, 1'b1);
        chk("coll_no_cnl", 32'(force_cnl), 32'd0);
        chk("coll_rel_gnt", 32'(gnt), 32'd0);
        step(4'b0000, 4'd0, 1'b0);
        step(4'b0000, 4'd0, 1'b0);

        // Abandonment, then asynchronous reset during CANCEL.
        wait_start(4'b0010, "abn_start_seen");
        for (int i = 0; i < 3; i++) step(4'b0010, 4'd0, 1'b0);
        step(4'b0000, 4'd0, 1'b0);
        chk("abn_cnl", 32'(force_cnl), 32'd1);
        #2;
        rst = 0;
        #1;
        chk("arst_gnt",  32'(gnt),       32'd0);
        chk("arst_busy", 32'(busy),      32'd0);
        chk("arst_cnl",  32'(force_cnl), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1;

        // Random traffic.
        rq = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < NP; b++)
                if ($urandom_range(0, 19) == 0) rq = rq ^ 4'(1 << b);
            ra = '0;
            for (int b = 0; b < NP; b++)
                if ($urandom_range(0, 5) == 0) ra = ra | 4'(1 << b);
            step(rq, ra, ($urandom_range(0, 9) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
